// File: rtl/bids22_pkg.sv
// Shared bids22 definitions: control opcodes, result encodings, round sequencer
// states and the round descriptor payload.
package bids22_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MASK_W          = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [3:0] {
    OP_NOOP      = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOCK      = 4'd2,
    OP_LOADX     = 4'd3,
    OP_LOADY     = 4'd4,
    OP_LOADZ     = 4'd5,
    OP_SETMASK   = 4'd6,
    OP_SETTIMER  = 4'd7,
    OP_BIDCHARGE = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_CFG_ERR = 2'd1,
    RES_TIMEOUT = 2'd2
  } res_status_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_X    = 2'd1,
    WIN_Y    = 2'd2,
    WIN_Z    = 2'd3
  } winner_e;

  typedef enum logic [3:0] {
    RC_IDLE, RC_UNLOCK, RC_LOAD_X, RC_LOAD_Y, RC_LOAD_Z, RC_SET_MASK,
    RC_SET_TIMER, RC_SET_COST, RC_LOCK, RC_RUN, RC_DRAIN, RC_REPORT
  } rc_state_e;

  // Sub-step of an op state: wait for ready, op on the bus, check err.
  typedef enum logic [1:0] {
    PH_ISSUE, PH_SHOW, PH_CHECK
  } rc_phase_e;

  typedef struct packed {
    logic [DATA_W-1:0] x_value;
    logic [DATA_W-1:0] y_value;
    logic [DATA_W-1:0] z_value;
    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] bid_cost;
    logic [DATA_W-1:0] key;
    logic [MASK_W-1:0] mask;
  } round_desc_t;

  // Op state that follows a successful op; LOCK hands over to RUN.
  function automatic rc_state_e rc_next_op(input rc_state_e s);
    case (s)
      RC_UNLOCK:    return RC_LOAD_X;
      RC_LOAD_X:    return RC_LOAD_Y;
      RC_LOAD_Y:    return RC_LOAD_Z;
      RC_LOAD_Z:    return RC_SET_MASK;
      RC_SET_MASK:  return RC_SET_TIMER;
      RC_SET_TIMER: return RC_SET_COST;
      RC_SET_COST:  return RC_LOCK;
      default:      return RC_RUN;
    endcase
  endfunction

  function automatic op_e rc_op_of(input rc_state_e s);
    case (s)
      RC_UNLOCK:    return OP_UNLOCK;
      RC_LOAD_X:    return OP_LOADX;
      RC_LOAD_Y:    return OP_LOADY;
      RC_LOAD_Z:    return OP_LOADZ;
      RC_SET_MASK:  return OP_SETMASK;
      RC_SET_TIMER: return OP_SETTIMER;
      RC_SET_COST:  return OP_BIDCHARGE;
      RC_LOCK:      return OP_LOCK;
      default:      return OP_NOOP;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rc_op_data(input rc_state_e s, input round_desc_t d);
    case (s)
      RC_UNLOCK, RC_LOCK: return d.key;
      RC_LOAD_X:          return d.x_value;
      RC_LOAD_Y:          return d.y_value;
      RC_LOAD_Z:          return d.z_value;
      RC_SET_MASK:        return DATA_W'(d.mask);
      RC_SET_TIMER:       return d.timer;
      RC_SET_COST:        return d.bid_cost;
      default:            return '0;
    endcase
  endfunction

  // X beats Y beats Z when several flags are raised together.
  function automatic winner_e encode_winner(input logic x, input logic y, input logic z);
    if (x)      return WIN_X;
    else if (y) return WIN_Y;
    else if (z) return WIN_Z;
    else        return WIN_NONE;
  endfunction

endpackage

// File: rtl/bids22_rc_cnt.sv
// Loadable down-counter with registered zero and one flags; saturates at zero.
module bids22_rc_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] count_q, count_d;
  logic         zero_q, one_q;

  // Next count: load wins over decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register; flags track the value being stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
      one_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
      one_q   <= (count_d == W'(1));
    end
  end

  assign zero_o = zero_q;
  assign one_o  = one_q;

endmodule

// File: rtl/bids22_round_ctrl.sv
// Round sequencer: takes a host descriptor, programs bids22 op by op, runs the
// round, waits for roundOver (bounded) and hands the outcome back to the host.
module bids22_round_ctrl
  import bids22_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_x_value,
  input  logic [31:0]       cfg_y_value,
  input  logic [31:0]       cfg_z_value,
  input  logic [2:0]        cfg_mask,
  input  logic [31:0]       cfg_timer,
  input  logic [31:0]       cfg_bid_cost,
  input  logic [31:0]       cfg_key,
  input  logic [LEN_W-1:0]  cfg_round_len,
  output logic [3:0]        C_op,
  output logic [31:0]       C_data,
  output logic              C_start,
  input  logic              ready,
  input  logic [1:0]        err,
  input  logic              roundOver,
  input  logic              X_win,
  input  logic              Y_win,
  input  logic              Z_win,
  input  logic [31:0]       maxBid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [1:0]        res_winner,
  output logic [31:0]       res_maxbid,
  output logic [1:0]        res_err,
  output logic              busy
);

  rc_state_e        state_q, state_d, nxt_op;
  rc_phase_e        phase_q, phase_d;
  round_desc_t      desc_q, desc_d;
  logic [LEN_W-1:0] len_q, len_d, run_len;
  logic             locked_q, locked_d;
  op_e              c_op_q, c_op_d;
  logic [31:0]      c_data_q, c_data_d;
  logic             c_start_q, c_start_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_status_q, res_status_d;
  logic [1:0]       res_winner_q, res_winner_d;
  logic [31:0]      res_maxbid_q, res_maxbid_d;
  logic [1:0]       res_err_q, res_err_d;
  logic             cfg_ready_q, busy_q;
  logic             run_load, run_dec, run_zero, run_one;
  logic             tmo_load, tmo_dec, tmo_zero, tmo_one;
  winner_e          win;

  assign run_len = (len_q == '0) ? LEN_W'(1) : len_q;
  assign win     = encode_winner(X_win, Y_win, Z_win);

  // Round length: C_start stays high while this counts down to one.
  bids22_rc_cnt #(.W(LEN_W)) u_run_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (run_load),
    .dec_i      (run_dec),
    .load_val_i (run_len),
    .zero_o     (run_zero),
    .one_o      (run_one)
  );

  // Drain watchdog: bounds the wait for roundOver.
  bids22_rc_cnt #(.W(LEN_W)) u_tmo_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmo_load),
    .dec_i      (tmo_dec),
    .load_val_i (LEN_W'(TIMEOUT_CYCLES)),
    .zero_o     (tmo_zero),
    .one_o      (tmo_one)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    desc_d       = desc_q;
    len_d        = len_q;
    locked_d     = locked_q;
    c_op_d       = OP_NOOP;
    c_data_d     = '0;
    c_start_d    = 1'b0;
    res_valid_d  = res_valid_q;
    res_status_d = res_status_q;
    res_winner_d = res_winner_q;
    res_maxbid_d = res_maxbid_q;
    res_err_d    = res_err_q;
    run_load     = 1'b0;
    run_dec      = 1'b0;
    tmo_load     = 1'b0;
    tmo_dec      = 1'b0;
    nxt_op       = rc_next_op(state_q);

    case (state_q)
      RC_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          desc_d = '{x_value: cfg_x_value, y_value: cfg_y_value, z_value: cfg_z_value,
                     timer: cfg_timer, bid_cost: cfg_bid_cost, key: cfg_key,
                     mask: cfg_mask};
          len_d   = cfg_round_len;
          state_d = locked_q ? RC_UNLOCK : RC_LOAD_X;
          phase_d = PH_ISSUE;
        end
      end
      RC_RUN: begin
        c_start_d = 1'b1;
        run_dec   = 1'b1;
        if (run_one || run_zero) begin
          c_start_d = 1'b0;
          tmo_load  = 1'b1;
          state_d   = RC_DRAIN;
        end
      end
      RC_DRAIN: begin
        if (roundOver) begin
          res_status_d = RES_OK;
          res_winner_d = win;
          res_maxbid_d = (win != WIN_NONE) ? maxBid : '0;
          res_err_d    = '0;
          res_valid_d  = 1'b1;
          state_d      = RC_REPORT;
        end else if (tmo_one || tmo_zero) begin
          res_status_d = RES_TIMEOUT;
          res_winner_d = WIN_NONE;
          res_maxbid_d = '0;
          res_err_d    = '0;
          res_valid_d  = 1'b1;
          state_d      = RC_REPORT;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      RC_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = RC_IDLE;
        end
      end
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            if (ready) begin
              c_op_d   = rc_op_of(state_q);
              c_data_d = rc_op_data(state_q, desc_q);
              phase_d  = PH_SHOW;
            end
          end
          PH_SHOW: phase_d = PH_CHECK;
          default: begin
            if (err != 2'b00) begin
              res_status_d = RES_CFG_ERR;
              res_err_d    = err;
              res_winner_d = WIN_NONE;
              res_maxbid_d = '0;
              res_valid_d  = 1'b1;
              state_d      = RC_REPORT;
            end else begin
              if (state_q == RC_UNLOCK) locked_d = 1'b0;
              if (state_q == RC_LOCK)   locked_d = 1'b1;
              state_d = nxt_op;
              if (nxt_op == RC_RUN) begin
                c_start_d = 1'b1;
                run_load  = 1'b1;
              end else if (ready) begin
                // Back-to-back issue: the next op goes out while this one retires.
                c_op_d   = rc_op_of(nxt_op);
                c_data_d = rc_op_data(nxt_op, desc_q);
                phase_d  = PH_SHOW;
              end else begin
                phase_d = PH_ISSUE;
              end
            end
          end
        endcase
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RC_IDLE;
      phase_q      <= PH_ISSUE;
      desc_q       <= '0;
      len_q        <= '0;
      locked_q     <= 1'b0;
      c_op_q       <= OP_NOOP;
      c_data_q     <= '0;
      c_start_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_status_q <= '0;
      res_winner_q <= '0;
      res_maxbid_q <= '0;
      res_err_q    <= '0;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      desc_q       <= desc_d;
      len_q        <= len_d;
      locked_q     <= locked_d;
      c_op_q       <= c_op_d;
      c_data_q     <= c_data_d;
      c_start_q    <= c_start_d;
      res_valid_q  <= res_valid_d;
      res_status_q <= res_status_d;
      res_winner_q <= res_winner_d;
      res_maxbid_q <= res_maxbid_d;
      res_err_q    <= res_err_d;
      cfg_ready_q  <= (state_d == RC_IDLE);
      busy_q       <= (state_d != RC_IDLE);
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign busy       = busy_q;
  assign C_op       = c_op_q;
  assign C_data     = c_data_q;
  assign C_start    = c_start_q;
  assign res_valid  = res_valid_q;
  assign res_status = res_status_q;
  assign res_winner = res_winner_q;
  assign res_maxbid = res_maxbid_q;
  assign res_err    = res_err_q;

endmodule

// File: tb/tb_bids22_round_ctrl.sv
// Bench for bids22_round_ctrl: a bids22 stand-in driven per scenario, with the
// expected op stream, run length and outcome derived from the round rules.
module tb_bids22_round_ctrl;

  localparam int LEN_W = 16;
  localparam int TMO   = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid, cfg_ready;
  logic [31:0]      cfg_x_value, cfg_y_value, cfg_z_value, cfg_timer, cfg_bid_cost, cfg_key;
  logic [2:0]       cfg_mask;
  logic [LEN_W-1:0] cfg_round_len;
  logic [3:0]       C_op;
  logic [31:0]      C_data;
  logic             C_start, ready, roundOver, X_win, Y_win, Z_win;
  logic [1:0]       err;
  logic [31:0]      maxBid;
  logic             res_valid, res_ready, busy;
  logic [1:0]       res_status, res_winner, res_err;
  logic [31:0]      res_maxbid;

  bids22_round_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x_value(cfg_x_value), .cfg_y_value(cfg_y_value), .cfg_z_value(cfg_z_value),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_bid_cost(cfg_bid_cost),
    .cfg_key(cfg_key), .cfg_round_len(cfg_round_len),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
    .roundOver(roundOver), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_winner(res_winner), .res_maxbid(res_maxbid), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, z, timer, cost, key, maxbid;
    logic [2:0]  mask;
    logic [15:0] len;
    int          err_op;    // opcode after which bids22 reports err (0: never)
    logic [1:0]  err_val;
    int          ro_delay;  // DRAIN cycle in which roundOver is seen (<0: never)
    logic        xw, yw, zw;
    bit          ready_low; // drop ready for 5 cycles right after SetXYZmask
    int          res_hold;  // cycles res_ready stays low
  } scen_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit model_locked = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic scen_t plan_scen();
    scen_t s;
    s.x = 32'd100; s.y = 32'd200; s.z = 32'd300; s.mask = 3'd7;
    s.timer = 32'd15; s.cost = 32'd1; s.key = 32'h0F0F0F0F; s.len = 16'd4;
    s.err_op = 0; s.err_val = 2'd0; s.ro_delay = 2;
    s.xw = 1'b0; s.yw = 1'b1; s.zw = 1'b0; s.maxbid = 32'd250;
    s.ready_low = 1'b0; s.res_hold = 3;
    return s;
  endfunction

  function automatic scen_t rand_scen();
    scen_t s;
    s.x = $urandom; s.y = $urandom; s.z = $urandom; s.mask = 3'($urandom);
    s.timer = $urandom; s.cost = $urandom; s.key = $urandom; s.len = 16'($urandom_range(0, 6));
    s.err_op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 8)) : 0;
    s.err_val = 2'($urandom_range(1, 3));
    s.ro_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 6));
    s.xw = 1'($urandom); s.yw = 1'($urandom); s.zw = 1'($urandom); s.maxbid = $urandom;
    s.ready_low = 1'b0; s.res_hold = int'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic do_round(input scen_t s);
    int          seq[$], exp_ops[$], got_ops[$], got_cyc[$];
    logic [31:0] dseq[$], exp_data[$], got_data[$];
    bit          aborted, lock_after, prev_start, done;
    int          exp_start, exp_lat, start_hi, fall, res_cyc, ready_back, rdy_cnt, hold;
    logic [1:0]  exp_status, exp_win, exp_err;
    logic [31:0] exp_max;

    // Expected op stream: Unlock first if the device was left locked.
    if (model_locked) begin seq.push_back(1); dseq.push_back(s.key); end
    seq.push_back(3); dseq.push_back(s.x);
    seq.push_back(4); dseq.push_back(s.y);
    seq.push_back(5); dseq.push_back(s.z);
    seq.push_back(6); dseq.push_back({29'd0, s.mask});
    seq.push_back(7); dseq.push_back(s.timer);
    seq.push_back(8); dseq.push_back(s.cost);
    seq.push_back(2); dseq.push_back(s.key);
    aborted = 1'b0;
    lock_after = model_locked;
    for (int i = 0; i < seq.size(); i++) begin
      exp_ops.push_back(seq[i]);
      exp_data.push_back(dseq[i]);
      if (seq[i] == s.err_op) begin aborted = 1'b1; break; end
      if (seq[i] == 1) lock_after = 1'b0;
      if (seq[i] == 2) lock_after = 1'b1;
    end

    exp_lat = 0;
    if (aborted) begin
      exp_status = 2'd1; exp_err = s.err_val; exp_win = 2'd0; exp_max = 32'd0; exp_start = 0;
    end else begin
      exp_err = 2'd0;
      exp_start = (s.len == 16'd0) ? 1 : int'(s.len);
      if (s.ro_delay < 0 || s.ro_delay > TMO - 1) begin
        exp_status = 2'd2; exp_win = 2'd0; exp_max = 32'd0; exp_lat = TMO;
      end else begin
        exp_status = 2'd0;
        exp_win = s.xw ? 2'd1 : (s.yw ? 2'd2 : (s.zw ? 2'd3 : 2'd0));
        exp_max = (exp_win != 2'd0) ? s.maxbid : 32'd0;
        exp_lat = s.ro_delay + 1;
      end
    end

    // Present the descriptor once the sequencer is idle.
    for (int t = 0; t < 50 && !cfg_ready; t++) tick();
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_x_value = s.x; cfg_y_value = s.y; cfg_z_value = s.z; cfg_mask = s.mask;
    cfg_timer = s.timer; cfg_bid_cost = s.cost; cfg_key = s.key; cfg_round_len = s.len;
    tick();
    cfg_valid = 1'b0;
    cfg_x_value = $urandom; cfg_y_value = $urandom; cfg_z_value = $urandom; cfg_mask = 3'($urandom);
    cfg_timer = $urandom; cfg_bid_cost = $urandom; cfg_key = $urandom; cfg_round_len = 16'($urandom);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("cfg_ready_after_accept", 64'(cfg_ready), 64'd0);

    start_hi = 0; fall = -1; res_cyc = -1; ready_back = -1; rdy_cnt = 0; hold = 0;
    prev_start = 1'b0; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      if (C_op != 4'd0) begin
        got_ops.push_back(int'(C_op)); got_data.push_back(C_data); got_cyc.push_back(cyc);
      end
      if (C_start) start_hi++;
      if (prev_start && !C_start) fall = cyc;
      prev_start = C_start;

      if (res_valid && res_cyc < 0) begin
        res_cyc = cyc;
        check("res_fields", {res_status, res_winner, res_err, res_maxbid},
              {exp_status, exp_win, exp_err, exp_max});
        if (!aborted) check("res_latency", 64'(res_cyc - fall), 64'(exp_lat));
        roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; err = 2'd0;
        if (s.res_hold == 0) res_ready = 1'b1;
      end else if (res_cyc >= 0) begin
        if (res_ready) begin
          check("res_valid_cleared", 64'(res_valid), 64'd0);
          res_ready = 1'b0;
          done = 1'b1;
        end else begin
          check("res_held", {res_valid, res_status, res_winner, res_err, res_maxbid},
                {1'b1, exp_status, exp_win, exp_err, exp_max});
          hold++;
          if (hold >= s.res_hold) res_ready = 1'b1;
        end
      end

      // bids22 stand-in reactions for the coming cycle.
      if (s.err_op != 0 && int'(C_op) == s.err_op) err = s.err_val;
      if (fall >= 0 && s.ro_delay >= 0 && cyc == fall + s.ro_delay && res_cyc < 0) begin
        roundOver = 1'b1; X_win = s.xw; Y_win = s.yw; Z_win = s.zw; maxBid = s.maxbid;
      end
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) begin ready = 1'b1; ready_back = cyc; end
      end else if (s.ready_low && C_op == 4'd6) begin
        ready = 1'b0; rdy_cnt = 5;
      end
    end

    check("round_done", 64'(done), 64'd1);
    check("start_high_cycles", 64'(start_hi), 64'(exp_start));
    check("op_count", 64'(got_ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      check($sformatf("op[%0d]", i), 64'(got_ops[i]), 64'(exp_ops[i]));
      check($sformatf("data[%0d]", i), 64'(got_data[i]), 64'(exp_data[i]));
      if (i > 0) begin
        if (s.ready_low && got_ops[i] == 7)
          check("settimer_after_ready", 64'(got_cyc[i] > ready_back && ready_back >= 0), 64'd1);
        else
          check($sformatf("op_gap[%0d]", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'd2);
      end
    end
    model_locked = lock_after;
  endtask

  initial begin
    scen_t s;
    reset = 1'b1; cfg_valid = 1'b0; cfg_x_value = '0; cfg_y_value = '0; cfg_z_value = '0;
    cfg_mask = '0; cfg_timer = '0; cfg_bid_cost = '0; cfg_key = '0; cfg_round_len = '0;
    ready = 1'b1; err = 2'd0; roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    maxBid = '0; res_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          {C_op, C_data, C_start, cfg_ready, res_valid, res_status, res_winner, res_err, res_maxbid, busy},
          {4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 32'd0, 1'b0});
    reset = 1'b0;

    // Plan round: Y wins 250 two cycles into drain, result held 3 cycles.
    do_round(plan_scen());
    // Same round again: device left locked, so Unlock with the key leads.
    do_round(plan_scen());
    // Config error right after LoadY.
    s = plan_scen(); s.err_op = 4; s.err_val = 2'b01;
    do_round(s);
    // roundOver never comes: timeout.
    s = plan_scen(); s.ro_delay = -1; s.res_hold = 0;
    do_round(s);
    // ready stalls around SetTimer, zero round length.
    s = plan_scen(); s.ready_low = 1'b1; s.len = 16'd0; s.ro_delay = 1;
    do_round(s);
    // roundOver already up on drain entry, all flags set: X has priority.
    s = plan_scen(); s.ro_delay = 0; s.xw = 1'b1; s.yw = 1'b1; s.zw = 1'b1; s.maxbid = 32'hDEADBEEF;
    do_round(s);
    // roundOver in the last watchdog cycle, no winner flag.
    s = plan_scen(); s.ro_delay = TMO - 1; s.yw = 1'b0; s.res_hold = 1;
    do_round(s);

    // Reset in the middle of RUN.
    cfg_valid = 1'b1; cfg_round_len = 16'd20; cfg_key = 32'h0F0F0F0F;
    for (int t = 0; t < 50 && !cfg_ready; t++) tick();
    tick();
    cfg_valid = 1'b0;
    for (int t = 0; t < 60 && !C_start; t++) tick();
    check("run_reached", 64'(C_start), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("reset_mid_run", {C_start, busy, C_op, res_valid, cfg_ready}, {1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    reset = 1'b0;
    tick();
    check("ready_after_reset", 64'(cfg_ready), 64'd1);
    model_locked = 1'b0;

    for (int r = 0; r < 6; r++) do_round(rand_scen());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
